// File: rtl/mc_recfg_delay_mem_pkg.sv
// Shared helpers for the multi-channel reconfigurable delay line:
// width helpers, length clamping and default field types.
package delay_chain_pkg;

  // Width needed to hold a length value in 0..max_len.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Width of a circular-buffer pointer for a buffer of max_len entries.
  function automatic int ptr_width(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

  // Saturate a requested length into the supported range.
  function automatic int clamp_len(input int len, input int min_len, input int max_len);
    if (len < min_len) return min_len;
    if (len > max_len) return max_len;
    return len;
  endfunction

  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_LW      = len_width(DEF_MAX_LEN);
  localparam int DEF_PW      = ptr_width(DEF_MAX_LEN);

  typedef logic [DEF_LW-1:0] len_t;
  typedef logic [DEF_PW-1:0] ptr_t;

endpackage

// File: rtl/mc_recfg_delay_mem_if.sv
// Per-channel stream bus: strobes, lengths and samples in; delayed samples out.
interface mc_recfg_delay_mem_if
  import delay_chain_pkg::*;
#(
  parameter int DW      = 8,
  parameter int CH      = 4,
  parameter int MAX_LEN = 16,
  parameter int LW      = len_width(MAX_LEN)
) ();

  logic [CH-1:0]    en;
  logic [CH-1:0]    clr;
  logic [CH*LW-1:0] length;
  logic [CH*DW-1:0] din;
  logic [CH*DW-1:0] dout;
  logic [CH-1:0]    dout_vld;

  modport master (
    output en, clr, length, din,
    input  dout, dout_vld
  );

  modport slave (
    input  en, clr, length, din,
    output dout, dout_vld
  );

endinterface

// File: rtl/mc_recfg_delay_mem_chan.sv
// One delay channel: circular sample buffer, write pointer, fill counter,
// registered output and a zero-length bypass path.
module delay_mem_chan
  import delay_chain_pkg::*;
#(
  parameter int DW      = 8,
  parameter int MAX_LEN = 16,
  parameter int MIN_LEN = 0,
  parameter int LW      = len_width(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic [LW-1:0] length,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          dout_vld
);

  localparam int PW = ptr_width(MAX_LEN);
  // Wide enough for wp + MAX_LEN during the modular read-address math.
  localparam int AW = LW + 1;

  logic [DW-1:0] mem [MAX_LEN];

  logic [PW-1:0] wp_q, wp_d;
  logic [LW-1:0] fill_q, fill_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          vld_q, vld_d;

  logic [LW-1:0] eff_len;
  logic [AW-1:0] back;
  logic [AW-1:0] base;
  logic [PW-1:0] rd_addr;
  logic          we;

  // Clamp the live length and locate the tap L-1 beats behind the write pointer.
  always_comb begin
    eff_len = LW'(clamp_len(int'(length), MIN_LEN, MAX_LEN));
    back    = AW'(eff_len) - AW'(1);
    base    = '0;
    if (AW'(wp_q) >= back) begin
      base = AW'(wp_q) - back;
    end else begin
      base = AW'(wp_q) + AW'(MAX_LEN) - back;
    end
    rd_addr = base[PW-1:0];
    // A clear on the same edge drops the incoming sample.
    we      = en & ~clr;
  end

  // Next-state for pointer, fill level and output register.
  always_comb begin
    wp_d   = wp_q;
    fill_d = fill_q;
    dout_d = dout_q;
    vld_d  = vld_q;
    if (clr) begin
      wp_d   = '0;
      fill_d = '0;
      vld_d  = 1'b0;
    end else if (en) begin
      wp_d   = (wp_q == PW'(MAX_LEN - 1)) ? '0 : wp_q + PW'(1);
      fill_d = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);
      vld_d  = (AW'(fill_q) + AW'(1)) >= AW'(eff_len);
      // L=1 means "this beat's sample"; it is not in the buffer yet.
      dout_d = (eff_len <= LW'(1)) ? din : mem[rd_addr];
    end
  end

  // Sample buffer: no reset, stale contents are masked by the fill count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wp_q] <= din;
    end
  end

  // State registers; reset discards all history at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q   <= '0;
      fill_q <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      wp_q   <= wp_d;
      fill_q <= fill_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
    end
  end

  // Zero length is a pure wire from din to dout.
  always_comb begin
    dout     = (eff_len == '0) ? din  : dout_q;
    dout_vld = (eff_len == '0) ? 1'b1 : vld_q;
  end

endmodule

// File: rtl/mc_recfg_delay_mem.sv
// Multi-channel run-time reconfigurable delay line: one independent
// memory-backed delay channel per lane, sliced out of flat buses.
module mc_recfg_delay_mem
  import delay_chain_pkg::*;
#(
  parameter int DW      = 8,
  parameter int CH      = 4,
  parameter int MAX_LEN = 16,
  parameter int MIN_LEN = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mc_recfg_delay_mem_if.slave   bus
);

  localparam int LW = len_width(MAX_LEN);

  logic [CH-1:0][DW-1:0] dout_w;
  logic [CH-1:0]         vld_w;

  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    delay_mem_chan #(
      .DW      (DW),
      .MAX_LEN (MAX_LEN),
      .MIN_LEN (MIN_LEN),
      .LW      (LW)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (bus.en[gi]),
      .clr      (bus.clr[gi]),
      .length   (bus.length[gi*LW +: LW]),
      .din      (bus.din[gi*DW +: DW]),
      .dout     (dout_w[gi]),
      .dout_vld (vld_w[gi])
    );
  end

  assign bus.dout     = dout_w;
  assign bus.dout_vld = vld_w;

endmodule
